// File: rtl/key_array_ctrl_pkg.sv
// Shared types for the key array front end: channel state encoding and counter sizing.
// Build option KEY_ARRAY_REPEAT_EN (see key_channel) does not change anything here.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DB_DN = 3'd1,
    HELD  = 3'd2,
    LONG  = 3'd3,
    DB_UP = 3'd4
  } key_st_t;

  // Width of a tick counter that must reach the largest of three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_array_ctrl_if.sv
// Bundle between the raw key pins / UI logic and the key array controller.
// Event outputs are single-cycle strobes with no backpressure: a consumer must
// sample them in the cycle they are high. dbg_state exposes each channel FSM.
interface key_array_ctrl_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0]      key;
  logic [NUM_KEYS-1:0]      key_state;
  logic [NUM_KEYS-1:0]      press;
  logic [NUM_KEYS-1:0]      release_p;
  logic [NUM_KEYS-1:0]      long_p;
  logic [NUM_KEYS-1:0]      rpt;
  logic                     any_press;
  logic [NUM_KEYS-1:0][2:0] dbg_state;

  modport master (
    output key,
    input  key_state, press, release_p, long_p, rpt, any_press, dbg_state
  );

  modport slave (
    input  key,
    output key_state, press, release_p, long_p, rpt, any_press, dbg_state
  );
endinterface

// File: rtl/key_array_ctrl_channel.sv
// One key channel: 2-flop synchroniser, debounce/long/repeat FSM and tick counter.
// KEY_ARRAY_REPEAT_EN enables rpt strobes in the LONG state; otherwise rpt stays 0.
module key_channel
  import key_pkg::*;
#(
  parameter logic KEY_DOWN_VAL = 1'b0,
  parameter int   DEBOUNCE_TK  = 20,
  parameter int   LONG_TK      = 1000,
  parameter int   REPEAT_TK    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_raw,
  output logic       key_state,
  output logic       press,
  output logic       release_p,
  output logic       long_p,
  output logic       rpt,
  output logic [2:0] dbg_state
);
  localparam int CW = cnt_width(DEBOUNCE_TK, LONG_TK, REPEAT_TK);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TK - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TK - 1);
`ifdef KEY_ARRAY_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_TK - 1);
`endif

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_DB_DN = DB_DN;
  localparam logic [2:0] S_HELD  = HELD;
  localparam logic [2:0] S_LONG  = LONG;
  localparam logic [2:0] S_DB_UP = DB_UP;

  logic          sync1, sync2, down;
  logic [2:0]    state;
  logic [CW-1:0] tcnt;
  logic          long_flag;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ~KEY_DOWN_VAL;
      sync2 <= ~KEY_DOWN_VAL;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign down      = (sync2 == KEY_DOWN_VAL);
  assign dbg_state = state;

  // Level changes are checked before tick so a coincident tick is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      long_flag <= 1'b0;
      key_state <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      press     <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      rpt       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (down) begin
            state <= S_DB_DN;
            tcnt  <= '0;
          end
        end
        S_DB_DN: begin
          if (!down) begin
            state <= S_IDLE;
            tcnt  <= '0;
          end else if (tick) begin
            if (tcnt == DB_LAST) begin
              state     <= S_HELD;
              press     <= 1'b1;
              key_state <= 1'b1;
              tcnt      <= '0;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!down) begin
            state <= S_DB_UP;
            tcnt  <= '0;
          end else if (tick) begin
            if (tcnt == LONG_LAST) begin
              state     <= S_LONG;
              long_p    <= 1'b1;
              long_flag <= 1'b1;
              tcnt      <= '0;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        S_LONG: begin
          if (!down) begin
            state <= S_DB_UP;
            tcnt  <= '0;
          end
`ifdef KEY_ARRAY_REPEAT_EN
          else if (tick) begin
            if (tcnt == RPT_LAST) begin
              rpt  <= 1'b1;
              tcnt <= '0;
            end else tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_DB_UP: begin
          if (down) begin
            state <= long_flag ? S_LONG : S_HELD;
            tcnt  <= '0;
          end else if (tick) begin
            if (tcnt == DB_LAST) begin
              state     <= S_IDLE;
              release_p <= 1'b1;
              key_state <= 1'b0;
              long_flag <= 1'b0;
              tcnt      <= '0;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_array_ctrl.sv
// Key array front end: shared tick prescaler feeding NUM_KEYS independent key channels.
// Define KEY_ARRAY_REPEAT_EN to get auto-repeat strobes on long-held keys.
module key_array_ctrl
  import key_pkg::*;
#(
  parameter int   NUM_KEYS     = 4,
  parameter logic KEY_DOWN_VAL = 1'b0,
  parameter int   TICK_DIV     = 50000,
  parameter int   DEBOUNCE_TK  = 20,
  parameter int   LONG_TK      = 1000,
  parameter int   REPEAT_TK    = 100
) (
  input logic             clk,
  input logic             rst,
  key_array_ctrl_if.slave kif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]            pcnt;
  logic                     tick;
  logic [NUM_KEYS-1:0]      key_state_w, press_w, release_w, long_w, rpt_w;
  logic [NUM_KEYS-1:0][2:0] state_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pcnt <= '0;
    else if (pcnt == P_LAST) pcnt <= '0;
    else                     pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == P_LAST);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .KEY_DOWN_VAL (KEY_DOWN_VAL),
      .DEBOUNCE_TK  (DEBOUNCE_TK),
      .LONG_TK      (LONG_TK),
      .REPEAT_TK    (REPEAT_TK)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .key_raw   (kif.key[i]),
      .key_state (key_state_w[i]),
      .press     (press_w[i]),
      .release_p (release_w[i]),
      .long_p    (long_w[i]),
      .rpt       (rpt_w[i]),
      .dbg_state (state_w[i])
    );
  end

  assign kif.key_state = key_state_w;
  assign kif.press     = press_w;
  assign kif.release_p = release_w;
  assign kif.long_p    = long_w;
  assign kif.rpt       = rpt_w;
  assign kif.any_press = |press_w;
  assign kif.dbg_state = state_w;

endmodule
